fp_if_arb: RTL and testbench

- Arbitrates the shared system-interface (memory/bus) channel between two requesters: the CPU microcode sequencer and the AWP (FPU) control unit.
- The AWP side raises its request from the F-PS state machine (the sr_fp/read_fp pair) and may hold the channel for a locked multi-word burst driven by its LP counter.
- Sequences one interface cycle at a time: grant, request, wait for answer, done. Detects no-answer timeouts.
- Sits between the CPU/AWP control units and the bus interface.

---
 rtl/fp_if_arb.sv | 108 ++++++++++
 tb/tb_fp_if_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fp_if_arb.sv
// Shared system-interface channel arbiter between the CPU sequencer and the AWP control unit.
// It runs one interface cycle at a time (grant, request, answer, done) and raises a sticky no-answer alarm.
module fp_if_arb #(
  parameter int                CNT_W   = 7,
  parameter logic [CNT_W-1:0]  TIMEOUT = 7'd100
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic req_cpu,
  input  logic rd_cpu,
  input  logic req_awp,
  input  logic rd_awp,
  input  logic lock_awp,
  input  logic if_ok,
  input  logic if_en,
  output logic gnt_cpu,
  output logic gnt_awp,
  output logic if_req,
  output logic if_rd,
  output logic done_cpu,
  output logic done_awp,
  output logic nack,
  output logic alarm,
  output logic busy
);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_WAIT, S_DONE, S_RELEASE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT - 1'b1;

  state_t           state_q, state_d;
  logic             own_awp_q;  // current owner, doubles as the round-robin "last" record
  logic             rd_q;
  logic [CNT_W-1:0] cnt_q;
  logic             nack_q;
  logic             alarm_q;

  logic take, win_awp, owner_req, timeout;

  assign owner_req = own_awp_q ? req_awp : req_cpu;
  assign timeout   = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    win_awp = own_awp_q;
    case (state_q)
      S_IDLE: begin
        // A locked AWP burst holds the channel: the CPU waits even while the AWP is between words.
        if (own_awp_q && lock_awp) begin
          if (req_awp) begin
            take    = 1'b1;
            win_awp = 1'b1;
          end
        end else if (req_cpu && req_awp) begin
          take    = 1'b1;
          win_awp = ~own_awp_q;
        end else if (req_cpu || req_awp) begin
          take    = 1'b1;
          win_awp = req_awp;
        end
        if (take) state_d = S_GRANT;
      end
      S_GRANT:   state_d = S_WAIT;
      S_WAIT:    if (if_ok || if_en || timeout) state_d = S_DONE;
      S_DONE:    state_d = S_RELEASE;
      S_RELEASE: if (!owner_req) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= S_IDLE;
      own_awp_q <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= '0;
      nack_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && take) begin
        own_awp_q <= win_awp;
        rd_q      <= win_awp ? rd_awp : rd_cpu;
      end
      if (state_q == S_GRANT)
        cnt_q <= '0;
      else if (state_q == S_WAIT && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
      // Only the value captured on the WAIT->DONE edge is ever shown; if_en dominates if_ok.
      if (state_q == S_WAIT) begin
        nack_q <= if_en | ~if_ok;
        if (!if_ok && !if_en && timeout) alarm_q <= 1'b1;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign gnt_awp  = busy &  own_awp_q;
  assign gnt_cpu  = busy & ~own_awp_q;
  assign if_req   = (state_q == S_WAIT);
  assign if_rd    = rd_q;
  assign done_awp = (state_q == S_DONE) &  own_awp_q;
  assign done_cpu = (state_q == S_DONE) & ~own_awp_q;
  assign nack     = (state_q == S_DONE) & nack_q;
  assign alarm    = alarm_q;

endmodule

// File: tb/tb_fp_if_arb.sv
// Bench for fp_if_arb: directed test-plan scenarios plus random transactions scored against
// a transaction-level model (round-robin winner, answer latency, nack/alarm outcome).
module tb_fp_if_arb;
  localparam int TO = 8;

  logic clk_sys, rst;
  logic req_cpu, rd_cpu, req_awp, rd_awp, lock_awp, if_ok, if_en;
  logic gnt_cpu, gnt_awp, if_req, if_rd, done_cpu, done_awp, nack, alarm, busy;

  int n_chk = 0;
  int n_err = 0;
  bit m_last_awp;
  bit m_alarm;

  fp_if_arb #(.CNT_W(7), .TIMEOUT(7'd8)) dut (
    .clk_sys(clk_sys), .rst(rst),
    .req_cpu(req_cpu), .rd_cpu(rd_cpu), .req_awp(req_awp), .rd_awp(rd_awp),
    .lock_awp(lock_awp), .if_ok(if_ok), .if_en(if_en),
    .gnt_cpu(gnt_cpu), .gnt_awp(gnt_awp), .if_req(if_req), .if_rd(if_rd),
    .done_cpu(done_cpu), .done_awp(done_awp), .nack(nack), .alarm(alarm), .busy(busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk_sys) begin
    if (!rst) begin
      chk("gnt_mutex", int'(gnt_cpu & gnt_awp), 0);
      chk("if_req_busy", int'(if_req & ~busy), 0);
      chk("done_overlap", int'(done_cpu & done_awp), 0);
    end
  end

  task automatic drop_owner(input bit awp);
    if (awp) req_awp = 1'b0;
    else     req_cpu = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    rst = 1'b1; req_cpu = 0; req_awp = 0; rd_cpu = 0; rd_awp = 0;
    lock_awp = 0; if_ok = 0; if_en = 0;
    @(negedge clk_sys);
    rst = 1'b0;
    chk("reset_outs", int'({gnt_cpu, gnt_awp, if_req, if_rd, done_cpu, done_awp, nack, alarm, busy}), 0);
    m_last_awp = 1'b0;
    m_alarm    = 1'b0;
  endtask

  // One interface transaction from grant to release; lat<0 skips the grant-latency check.
  task automatic run_cycle(input bit awp, input bit rd, input int k, input bit ok, input bit en,
                           input bit early, input int h, input int lat);
    int n;
    int waits;
    bit got;
    bit tmo;
    got = 1'b0;
    for (n = 0; n < 6; n++) begin
      @(negedge clk_sys);
      if (gnt_cpu || gnt_awp) begin
        got = 1'b1;
        break;
      end
    end
    chk("grant_seen", int'(got), 1);
    if (!got) begin
      req_cpu = 0; req_awp = 0;
      return;
    end
    if (lat >= 0) chk("grant_lat", n, lat);
    chk("gnt_awp", int'(gnt_awp), int'(awp));
    chk("gnt_cpu", int'(gnt_cpu), int'(!awp));
    chk("setup_no_req", int'(if_req), 0);
    chk("if_rd", int'(if_rd), int'(rd));
    waits = 0;
    for (int j = 0; j < TO + 3; j++) begin
      @(negedge clk_sys);
      if_ok = 1'b0; if_en = 1'b0;
      if (!if_req) break;
      waits++;
      if (early && waits == 1) drop_owner(awp);
      if (waits == k) begin
        if_ok = ok; if_en = en;
      end
    end
    tmo = !(ok || en);
    chk("wait_len", waits, tmo ? TO : k);
    m_alarm    = m_alarm | tmo;
    m_last_awp = awp;
    chk("done_awp", int'(done_awp), int'(awp));
    chk("done_cpu", int'(done_cpu), int'(!awp));
    chk("nack", int'(nack), int'(en || tmo));
    chk("alarm", int'(alarm), int'(m_alarm));
    chk("done_gnt", int'(awp ? gnt_awp : gnt_cpu), 1);
    for (int i = 0; i <= h; i++) begin
      @(negedge clk_sys);
      chk("rel_gnt", int'(awp ? gnt_awp : gnt_cpu), 1);
      chk("rel_no_done", int'(done_cpu | done_awp), 0);
      chk("rel_no_nack", int'(nack), 0);
      if (i == h) drop_owner(awp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int v, mode, k, k2, mode2;
    bit rc, ra, rdc, rda, exp_awp, early, early2;
    int h, h2;
    rst = 1'b1; req_cpu = 0; req_awp = 0; rd_cpu = 0; rd_awp = 0;
    lock_awp = 0; if_ok = 0; if_en = 0;
    m_last_awp = 0; m_alarm = 0;
    do_reset();

    // Single CPU read, answered after three WAIT cycles, owner holds req one extra cycle.
    @(negedge clk_sys); req_cpu = 1; rd_cpu = 1;
    run_cycle(1'b0, 1'b1, 3, 1'b1, 1'b0, 1'b0, 1, 0);
    @(negedge clk_sys);
    chk("idle_after_release", int'(busy), 0);

    // No answer at all: timeout, sticky alarm.
    req_awp = 1; rd_awp = 0;
    run_cycle(1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      chk("alarm_sticky", int'(alarm), 1);
    end

    // if_ok and if_en together: nack without alarm.
    do_reset();
    @(negedge clk_sys); req_awp = 1; rd_awp = 1;
    run_cycle(1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b0, 0, 0);

    // Locked AWP burst of three words with the CPU waiting throughout.
    do_reset();
    @(negedge clk_sys); lock_awp = 1; req_cpu = 1; rd_cpu = 0; req_awp = 1; rd_awp = 1;
    run_cycle(1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0, 0, 0);
    for (int w = 1; w < 3; w++) begin
      @(negedge clk_sys);
      chk("lock_cpu_blocked", int'(gnt_cpu), 0);
      @(negedge clk_sys);
      chk("lock_cpu_blocked", int'(gnt_cpu), 0);
      chk("lock_idle", int'(busy), 0);
      req_awp = 1;
      run_cycle(1'b1, 1'b1, w, 1'b1, 1'b0, 1'b0, 0, 0);
    end
    lock_awp = 0;
    run_cycle(1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 0, 1);

    // Reset in the middle of WAIT.
    do_reset();
    @(negedge clk_sys); req_cpu = 1; rd_cpu = 1;
    @(negedge clk_sys);
    @(negedge clk_sys);
    chk("pre_reset_wait", int'(if_req), 1);
    @(negedge clk_sys); rst = 1;
    @(negedge clk_sys);
    chk("midwait_reset_outs",
        int'({gnt_cpu, gnt_awp, if_req, if_rd, done_cpu, done_awp, nack, alarm, busy}), 0);
    rst = 0;
    m_last_awp = 0; m_alarm = 0;
    run_cycle(1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0, 0, 0);

    // Random transactions.
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) == 0) do_reset();
      v   = $urandom_range(1, 3);
      rc  = v[0];
      ra  = v[1];
      rdc = 1'($urandom_range(0, 1));
      rda = 1'($urandom_range(0, 1));
      mode  = $urandom_range(0, 3);
      k     = $urandom_range(1, TO - 2);
      early = ($urandom_range(0, 3) == 0);
      h     = early ? 0 : $urandom_range(0, 2);
      exp_awp = ra && (!rc || !m_last_awp);
      @(negedge clk_sys);
      req_cpu = rc; req_awp = ra; rd_cpu = rdc; rd_awp = rda;
      run_cycle(exp_awp, exp_awp ? rda : rdc, k, mode == 0 || mode == 2, mode == 1 || mode == 2,
                early, h, 0);
      if (rc && ra) begin
        mode2  = $urandom_range(0, 3);
        k2     = $urandom_range(1, TO - 2);
        early2 = ($urandom_range(0, 3) == 0);
        h2     = early2 ? 0 : $urandom_range(0, 2);
        run_cycle(!exp_awp, exp_awp ? rdc : rda, k2, mode2 == 0 || mode2 == 2,
                  mode2 == 1 || mode2 == 2, early2, h2, 1);
      end
    end

    @(negedge clk_sys);
    chk("final_idle", int'(busy), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
